// File: rtl/regfile_scoreboard.sv
// Integer register file: two combinational read ports and one posedge write port with optional bypass,
// plus a per-register pending-write scoreboard that drives the decode stall and a pending-write counter.
module regfile_scoreboard #(
  parameter  int unsigned XLEN     = 32,
  parameter  int unsigned NREGS    = 32,
  parameter  bit          ZERO_REG = 1'b1,
  parameter  bit          BYPASS   = 1'b1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            srst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            stall,
  output logic [AW:0]     pending_cnt
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_ok, issue_ok, hit1, hit2;

  // An address is architecturally live when in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    wr_ok    = we && addr_ok(wr_addr);
    hit1     = BYPASS && wr_ok && (wr_addr == rs1_addr);
    hit2     = BYPASS && wr_ok && (wr_addr == rs2_addr);
    rd1      = '0;
    rd2      = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (!srst && addr_ok(rs1_addr)) begin
      rd1      = hit1 ? wr_data : mem_q[rs1_addr];
      rs1_busy = busy_q[rs1_addr] && !hit1;
    end
    if (!srst && addr_ok(rs2_addr)) begin
      rd2      = hit2 ? wr_data : mem_q[rs2_addr];
      rs2_busy = busy_q[rs2_addr] && !hit2;
    end
    stall    = (rs1_busy && rs1_used) || (rs2_busy && rs2_used);
    issue_ok = issue_valid && !stall && !flush && addr_ok(issue_rd);
  end

  // Flush wipes all producers; otherwise a new issue beats a same-register writeback.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_ok)    busy_d[wr_addr]  = 1'b0;
      if (issue_ok) busy_d[issue_rd] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + (AW+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default build, a BYPASS=0 build and an NREGS=24 build,
// all driven from one shared stimulus.
module tb_regfile_scoreboard;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic            clk = 1'b0;
  logic            srst;
  logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, issue_rd;
  logic            rs1_used, rs2_used, we, issue_valid, flush;
  logic [XLEN-1:0] wr_data;

  logic [XLEN-1:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
  logic            a_b1, a_b2, a_stall, b_b1, b_b2, b_stall, c_b1, c_b2, c_stall;
  logic [AW:0]     a_cnt, b_cnt, c_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_scoreboard u_a (
    .clk(clk), .srst(srst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd1(a_rd1), .rd2(a_rd2),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .rs1_busy(a_b1), .rs2_busy(a_b2),
    .stall(a_stall), .pending_cnt(a_cnt));

  regfile_scoreboard #(.BYPASS(1'b0)) u_b (
    .clk(clk), .srst(srst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd1(b_rd1), .rd2(b_rd2),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .rs1_busy(b_b1), .rs2_busy(b_b2),
    .stall(b_stall), .pending_cnt(b_cnt));

  regfile_scoreboard #(.NREGS(24)) u_c (
    .clk(clk), .srst(srst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd1(c_rd1), .rd2(c_rd2),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .rs1_busy(c_b1), .rs2_busy(c_b2),
    .stall(c_stall), .pending_cnt(c_cnt));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge, well clear of both edges.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    srst = 1'b1; rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    we = 1'b0; wr_addr = '0; wr_data = '0; issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    #3;
    chk("reset_rd1", a_rd1, 0);
    chk("reset_cnt", a_cnt, 0);
    chk("reset_stall", a_stall, 0);
    #9 srst = 1'b0;
    tick();

    // write 5 with same-cycle bypass
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5;
    #1;
    chk("bypass_rd1", a_rd1, 32'hDEADBEEF);
    chk("nobypass_rd1_old", b_rd1, 0);
    tick();
    we = 1'b0;
    #1;
    chk("stored_rd1", a_rd1, 32'hDEADBEEF);
    chk("nobypass_rd1_new", b_rd1, 32'hDEADBEEF);

    // x0 ignores writes and issues
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rs1_addr = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    chk("x0_rd1_bypass", a_rd1, 0);
    tick();
    we = 1'b0; issue_valid = 1'b0;
    #1;
    chk("x0_rd1", a_rd1, 0);
    chk("x0_cnt", a_cnt, 0);
    chk("x0_busy", a_b1, 0);

    // issue x7, stall on it, blocked issue to x9, writeback releases
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_rd = 5'd9; rs2_addr = 5'd7; rs2_used = 1'b1;
    #1;
    chk("x7_cnt", a_cnt, 1);
    chk("x7_stall", a_stall, 1);
    chk("x7_busy", a_b2, 1);
    tick();
    #1;
    chk("x9_suppressed_cnt", a_cnt, 1);
    issue_valid = 1'b0; we = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    #1;
    chk("wb7_stall", a_stall, 0);
    chk("wb7_rd2", a_rd2, 32'h55);
    chk("nobypass_wb7_stall", b_stall, 1);
    chk("nobypass_wb7_rd2", b_rd2, 0);
    tick();
    we = 1'b0;
    #1;
    chk("wb7_cnt", a_cnt, 0);
    chk("nobypass_after_stall", b_stall, 0);
    chk("nobypass_after_rd2", b_rd2, 32'h55);

    // issue x3, then issue+writeback x3 together: set wins
    rs2_used = 1'b0; rs1_addr = 5'd3; rs1_used = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    #1;
    chk("x3_cnt", a_cnt, 1);
    chk("x3_unused_stall", a_stall, 0);
    chk("nobypass_x3_busy", b_b1, 1);
    chk("nobypass_x3_unused_stall", b_stall, 0);
    tick();
    we = 1'b0; issue_valid = 1'b0;
    #1;
    chk("x3_setwins_cnt", a_cnt, 1);
    chk("x3_setwins_busy", a_b1, 1);

    // clear x3 while issuing x1, then x2, x4; flush with issue x6 and a write to x10
    issue_valid = 1'b1; issue_rd = 5'd1; we = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick();
    we = 1'b0; issue_rd = 5'd2;
    tick();
    issue_rd = 5'd4;
    tick();
    #1;
    chk("three_cnt", a_cnt, 3);
    flush = 1'b1; issue_rd = 5'd6; we = 1'b1; wr_addr = 5'd10; wr_data = 32'hA5A5;
    tick();
    flush = 1'b0; issue_valid = 1'b0; we = 1'b0; rs1_addr = 5'd6; rs2_addr = 5'd10;
    #1;
    chk("flush_cnt", a_cnt, 0);
    chk("flush_x6_busy", a_b1, 0);
    chk("flush_write_rd2", a_rd2, 32'hA5A5);
    rs1_addr = 5'd1;
    #1;
    chk("flush_x1_busy", a_b1, 0);

    // asynchronous reset mid-operation
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd12; rs2_used = 1'b1;
    #1;
    chk("pre_rst_stall", a_stall, 1);
    chk("pre_rst_rd1", a_rd1, 32'hDEADBEEF);
    #2 srst = 1'b1;
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF;
    #1;
    chk("rst_rd1", a_rd1, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_busy", a_b2, 0);
    chk("rst_cnt", a_cnt, 0);
    #1 srst = 1'b0; we = 1'b0;
    tick();
    #1;
    chk("post_rst_rd1", a_rd1, 0);
    chk("post_rst_stall", a_stall, 0);
    rs2_addr = 5'd10;
    #1;
    chk("post_rst_rd2", a_rd2, 0);

    // out-of-range address on the NREGS=24 build
    rs2_used = 1'b0; rs1_addr = 5'd30; we = 1'b1; wr_addr = 5'd30; wr_data = 32'hBAD;
    issue_valid = 1'b1; issue_rd = 5'd30;
    #1;
    chk("oor_bypass_rd1", c_rd1, 0);
    tick();
    we = 1'b0; issue_valid = 1'b0;
    #1;
    chk("oor_rd1", c_rd1, 0);
    chk("oor_cnt", c_cnt, 0);
    chk("inrange_rd1", a_rd1, 32'hBAD);
    chk("inrange_cnt", a_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
